// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: command-master FSM encoding and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrAwW = 3'd1,
    StWrB   = 3'd2,
    StRdAr  = 3'd3,
    StRdR   = 3'd4,
    StRsp   = 3'd5
  } axil_state_e;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespSlverr = 2'b10;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: turns one register command into one AXI-Lite
// write or read transaction and returns the captured response.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [31:0]       WDATA,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP
);

  axil_state_e       r_state, w_state_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]        r_rsp_resp, w_rsp_resp_nxt;
  logic              r_awvalid, w_awvalid_nxt;
  logic              r_wvalid, w_wvalid_nxt;
  logic              r_bready, w_bready_nxt;
  logic              r_arvalid, w_arvalid_nxt;
  logic              r_rready, w_rready_nxt;
  logic              r_aw_done, w_aw_done_nxt;
  logic              r_w_done, w_w_done_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;

  // Every handshake output is a flop, so no input reaches an output combinationally.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;

    unique case (r_state)
      StIdle: begin
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          w_addr_nxt      = cmd_addr;
          w_wdata_nxt     = cmd_wdata;
          w_aw_done_nxt   = 1'b0;
          w_w_done_nxt    = 1'b0;
          if (cmd_we) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = StWrAwW;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = StRdAr;
          end
        end
      end
      StWrAwW: begin
        if (r_awvalid && AWREADY) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (r_wvalid && WREADY) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = StWrB;
        end
      end
      StWrB: begin
        if (BVALID && r_bready) begin
          w_bready_nxt    = 1'b0;
          w_rsp_resp_nxt  = BRESP;
          w_rsp_rdata_nxt = 32'h0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = StRsp;
        end
      end
      StRdAr: begin
        if (r_arvalid && ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = StRdR;
        end
      end
      StRdR: begin
        if (RVALID && r_rready) begin
          w_rready_nxt    = 1'b0;
          w_rsp_rdata_nxt = RDATA;
          w_rsp_resp_nxt  = RRESP;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready && r_rsp_valid) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_resp  <= 2'b00;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign AWVALID   = r_awvalid;
  assign AWADDR    = r_addr;
  assign WVALID    = r_wvalid;
  assign WDATA     = r_wdata;
  assign BREADY    = r_bready;
  assign ARVALID   = r_arvalid;
  assign ARADDR    = r_addr;
  assign RREADY    = r_rready;

endmodule
